// File: rtl/logic_shift_unit_pkg.sv
// logic_shift_pkg: op and state encodings shared by the logic/shift unit
package logic_shift_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_XOR = 3'b010,
      OP_XNOR = 3'b011,
      OP_SHL = 3'b100,
      OP_SHR = 3'b101,
      OP_ROL = 3'b110,
      OP_ROR = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   function automatic logic is_shift(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/logic_shift_unit_if.sv
// logic_shift_unit_if: operand/result handshake bundle of the logic/shift unit
interface logic_shift_unit_if #(
   parameter int WIDTH = 4
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       A;
   logic [WIDTH-1:0]       B;
   logic [2:0]             op;
   logic                   out_valid;
   logic                   out_ready;
   logic [2*WIDTH-1:0]     result;
   logic                   carry_out;
   logic                   zero;

   modport master (
      output in_valid, A, B, op, out_ready,
      input  in_ready, out_valid, result, carry_out, zero
   );

   modport slave (
      input  in_valid, A, B, op, out_ready,
      output in_ready, out_valid, result, carry_out, zero
   );
endinterface

// File: rtl/logic_shift_unit_shift_step.sv
// shift_step: one-position shift/rotate of a WIDTH-bit word, reporting the bit that leaves
module shift_step
   import logic_shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] work,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] next_work,
   output logic             out_bit
);
   logic left, rot;

   assign left      = op == OP_SHL || op == OP_ROL;
   assign rot       = op == OP_ROL || op == OP_ROR;
   assign out_bit   = left ? work[WIDTH-1] : work[0];
   // rotates feed the departing bit back in; plain shifts insert 0
   assign next_work = left ? {work[WIDTH-2:0], rot & out_bit}
                           : {rot & out_bit, work[WIDTH-1:1]};
endmodule

// File: rtl/logic_shift_unit.sv
// logic_shift_unit: handshaked logic ops plus iterative one-bit-per-cycle shifts/rotates
module logic_shift_unit
   import logic_shift_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input logic               clk,
   input logic               rst_n,
   logic_shift_unit_if.slave bus
);
   state_e             state, state_d;
   logic [2:0]         op_q;
   logic [SHAMT_W-1:0] cnt, k;
   logic [WIDTH-1:0]   work, r_q, logic_r, accept_r, next_work;
   logic               carry_q, zero_q, out_bit, accept, last;

   assign k        = bus.B[SHAMT_W-1:0];
   assign accept   = state == S_IDLE && bus.in_valid;
   assign last     = cnt == SHAMT_W'(1);
   assign logic_r  = bus.op == OP_AND ? bus.A & bus.B :
                     bus.op == OP_OR  ? bus.A | bus.B :
                     bus.op == OP_XOR ? bus.A ^ bus.B : ~(bus.A ^ bus.B);
   // a shift with k=0 finishes immediately with r = A, so A is the accept-time result
   assign accept_r = is_shift(bus.op) ? bus.A : logic_r;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .work      (work),
      .op        (op_q),
      .next_work (next_work),
      .out_bit   (out_bit)
   );

   always_ff @(posedge clk) state <= rst_n ? state_d : S_IDLE;

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  state_d = accept ? ((is_shift(bus.op) && k != '0) ? S_SHIFT : S_DONE) : S_IDLE;
         S_SHIFT: state_d = last ? S_DONE : S_SHIFT;
         S_DONE:  state_d = bus.out_ready ? S_IDLE : S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q    <= '0;
         cnt     <= '0;
         work    <= '0;
         r_q     <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else if (accept) begin
         op_q    <= bus.op;
         cnt     <= is_shift(bus.op) ? k : '0;
         work    <= is_shift(bus.op) ? bus.A : '0;
         r_q     <= accept_r;
         carry_q <= 1'b0;
         zero_q  <= accept_r == '0;
      end else if (state == S_SHIFT) begin
         work    <= next_work;
         cnt     <= cnt - SHAMT_W'(1);
         r_q     <= next_work;
         carry_q <= out_bit;
         zero_q  <= next_work == '0;
      end
   end

   assign bus.in_ready  = state == S_IDLE;
   assign bus.out_valid = state == S_DONE;
   assign bus.result    = {{WIDTH{1'b0}}, r_q};
   assign bus.carry_out = carry_q;
   assign bus.zero      = zero_q;
endmodule

// File: doc/logic_shift_unit.md
# logic_shift_unit

Parametrised, handshaked successor to the ALU's combinational logic-op slice. It adds NOT/XNOR-class ops, iterative shifts and rotates (one bit position per cycle), zero and carry flags, and valid/ready flow control on both sides. It sits in the ALU datapath beside the arithmetic unit and drives the shared `2*WIDTH`-wide result bus with the upper half zeroed.

## Interface
Parameters:
- `WIDTH`, default 4: operand width; must be a power of two ≥ 2.
- `SHAMT_W`, default `$clog2(WIDTH)`: shift-amount width. It is derived and is not overridden.

Ports:
- `clk`  in  1  clock. The block uses one clock domain; all state changes on `posedge clk`.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  the operand/op set is valid.
- `in_ready`  out  1  the block can accept an operation.
- `A`  in  WIDTH  operand A; the shift/rotate source.
- `B`  in  WIDTH  operand B for logic ops; `B[SHAMT_W-1:0]` is the shift amount k.
- `op`  in  3  operation select:
  - 000 AND, 001 OR, 010 XOR, 011 XNOR
  - 100 SHL, 101 SHR (logical), 110 ROL, 111 ROR
- `out_valid`  out  1  the result is valid.
- `out_ready`  in  1  the consumer accepts the result.
- `result`  out  2*WIDTH  `{WIDTH'b0, r}`.
- `carry_out`  out  1  the last bit shifted or rotated out; 0 for logic ops and when k=0.
- `zero`  out  1  high when `r == 0`.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE.
- `in_ready` is 1 only in IDLE. `out_valid` is 1 only in DONE.
- **Accept:** happens when `in_valid && in_ready`. A, op and k are captured, and `work <= A` for shift ops.
  - Logic op: `r` is computed at the accept edge. The FSM moves to DONE with carry 0.
  - Shift/rotate op with k=0: `r = A` and carry 0. The FSM moves to DONE.
  - Shift/rotate op with k>0: the FSM moves to SHIFT with `cnt = k`.
- **SHIFT:** each edge performs one single-position step on `work`, latches the bit that left into `carry`, and decrements `cnt`.
  - When `cnt` reaches 0, the FSM moves to DONE.
- **Bit leaving on each step:**
  - SHL: `work[WIDTH-1]` leaves; 0 enters at the LSB.
  - SHR: `work[0]` leaves; 0 enters at the MSB.
  - ROL/ROR: the wrapped bit is fed back into the word and is also recorded as carry.
- **DONE:** `result`, `carry_out` and `zero` are held stable while `out_ready` is 0. On `out_ready` the FSM returns to IDLE.
- **Ignored inputs:**
  - Input values are ignored in SHIFT and DONE; the captured copies are used.
  - `in_valid` asserted outside IDLE is ignored. No accept occurs there.
- **Width rules:**
  - k ranges over 0..WIDTH-1 (modulo WIDTH by construction).
  - Shifted-out bits are never propagated into `result[2*WIDTH-1:WIDTH]`. The upper half is always 0.
- **Reset:** on any cycle with `rst_n` = 0, including mid-SHIFT and in DONE, the next state is IDLE.
  - Reset values: `in_ready` 1, `out_valid` 0, `result` 0, `carry_out` 0, `zero` 0.
  - `cnt`, `work` and captured operands clear to 0. An in-flight operation is discarded with no output.

## Timing
- Latency runs from the accept edge to the first cycle with `out_valid` = 1.
  - The first cycle after the accept edge counts as 1.
  - Latency is 1 + k cycles. Logic ops and k=0 give 1 cycle; k=WIDTH-1 gives WIDTH cycles.
- The result handshake completes on an edge with `out_valid && out_ready`. `in_ready` is 1 in the following cycle.
- Maximum throughput is one logic op per 2 cycles: accept edge, then DONE with `out_ready` = 1.
- Outputs come straight from registers. There is no combinational path from `in_*` to `out_*`.
- `in_ready` depends only on state, not on `out_ready`.

## Structure
- Shared package `logic_shift_pkg` holds:
  - the op encodings: `OP_AND`…`OP_ROR`;
  - the state encodings: `S_IDLE`, `S_SHIFT`, `S_DONE`;
  - the `is_shift(op)` helper, which returns `op[2]`.
- Natural sub-module `shift_step`: a combinational single-position shift/rotate over `WIDTH` bits, with outputs `next_work` and `out_bit`.
  - It is instantiated once and used every SHIFT cycle.
- Logic-op evaluation stays inline.

## Test plan
All values below use WIDTH=4.
- AND, A=1100, B=1010, `out_ready`=1 → after 1 cycle: `result`=0x08, `carry_out`=0, `zero`=0. `in_ready` returns 1 on the next cycle.
- XOR, A=B=0101 → `result`=0x00, `zero`=1, `carry_out`=0, latency 1.
- SHL, A=1011, B=0011 (k=3) → `out_valid` after 4 cycles: `result`=0x08, `carry_out`=1. `in_ready` stays 0 throughout.
- ROR, A=1001, k=1 → latency 2: `result`=0x0C, `carry_out`=1. Then SHR with k=0 on A=0110 → latency 1: `result`=0x06, `carry_out`=0.
- Backpressure: OR result ready, `out_ready` held 0 for 5 cycles with `in_valid`=1 and changing A/B.
  - Required: `result`, flags and `out_valid` stay stable; `in_ready` stays 0; no second accept.
  - After `out_ready`=1 for one edge: IDLE, then exactly one new accept.
- Reset mid-op: SHR with k=3 accepted, then `rst_n`=0 on the 2nd SHIFT cycle.
  - Required on the next edge: `in_ready`=1, `out_valid`=0, `result`=0, `carry_out`=0.
  - The aborted result never appears.
